// File: rtl/ad_align_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ad_align_pkg
// Brief   : Shared state encoding and default patterns for the AD9252 aligner.
// Revision: 1.0 - initial release
// ============================================================================
package ad_align_pkg;

    typedef enum logic [2:0] {
        ST_RST_SERDES = 3'd0,
        ST_WAIT_SPI   = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_CHECK      = 3'd3,
        ST_SLIP       = 3'd4,
        ST_SLIP_WAIT  = 3'd5,
        ST_TEST_CHK   = 3'd6,
        ST_LOCKED     = 3'd7
    } align_state_t;

    localparam logic [13:0] c_frame_pat = 14'h3F80;
    localparam logic [13:0] c_test_pat  = 14'h2AAA;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad_pattern_chk.sv
`default_nettype none
// ============================================================================
// Module  : ad_pattern_chk
// Brief   : Registered per-channel test-pattern compare with sticky pass flags.
// Revision: 1.0 - initial release
// ============================================================================
module ad_pattern_chk
    import ad_align_pkg::*;
#(
    parameter int                N_CH     = 8,
    parameter int                DATA_W   = 14,
    parameter logic [DATA_W-1:0] TEST_PAT = c_test_pat
) (
    input  logic                     clk_dco_div,
    input  logic                     reset,
    input  logic                     preset,
    input  logic                     enable,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH-1:0]          flags
);

    logic [N_CH-1:0] w_eq;
    logic [N_CH-1:0] r_eq;
    logic [N_CH-1:0] r_flags;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_eq[gi] = (ch_data[gi*DATA_W +: DATA_W] == TEST_PAT);
    end

    always_ff @(posedge clk_dco_div or posedge reset) begin
        if (reset) begin
            r_eq    <= '0;
            r_flags <= '0;
        end else begin
            r_eq <= w_eq;
            if (preset) begin
                r_flags <= '1;
            end else if (enable) begin
                r_flags <= r_flags & r_eq;
            end
        end
    end

    // Includes the compare being folded in this cycle, so a final-cycle load sees it.
    assign flags = r_flags & r_eq;

endmodule
`default_nettype wire

// File: rtl/ad_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ad_align_ctrl
// Brief   : AD9252 LVDS bring-up: serdes reset, bitslip word alignment, test check.
// Revision: 1.0 - initial release
// ============================================================================
module ad_align_ctrl
    import ad_align_pkg::*;
#(
    parameter int                N_CH       = 8,
    parameter int                DATA_W     = 14,
    parameter logic [DATA_W-1:0] FRAME_PAT  = c_frame_pat,
    parameter logic [DATA_W-1:0] TEST_PAT   = c_test_pat,
    parameter int                RST_CYC    = 8,
    parameter int                SETTLE_CYC = 16,
    parameter int                SLIP_WAIT  = 4,
    parameter int                MATCH_CNT  = 8
) (
    input  logic                     clk_dco_div,
    input  logic                     reset,
    input  logic                     dco_soft_rst,
    input  logic                     dco_spi_done,
    input  logic                     dco_test_mode,
    input  logic [DATA_W-1:0]        frame_word,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic                     serdes_rst,
    output logic                     bitslip,
    output logic                     aligned,
    output logic                     align_err,
    output logic                     lock_lost,
    output logic [N_CH-1:0]          ch_ok,
    output logic [3:0]               slip_cnt,
    output logic [2:0]               state_dbg
);

    localparam int c_cnt_max = max_int(max_int(RST_CYC, SETTLE_CYC), max_int(SLIP_WAIT, MATCH_CNT));
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    align_state_t        r_state, w_state_nxt;
    logic                r_fail, w_fail_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [c_cnt_w-1:0]  r_match, w_match_nxt;
    logic [3:0]          r_slip, w_slip_nxt;
    logic                r_bitslip, w_bitslip_nxt;
    logic                r_aligned, w_aligned_nxt;
    logic                r_align_err, w_align_err_nxt;
    logic                r_lock_lost, w_lock_lost_nxt;
    logic                r_serdes_rst;
    logic [N_CH-1:0]     r_ch_ok;
    logic                r_frame_match, r_spi_d, r_test_d;
    logic                w_preset, w_ch_ok_ld, w_ch_ok_clr;
    logic                w_spi_fall, w_test_rise;
    logic [N_CH-1:0]     w_flags;

    assign w_spi_fall  = r_spi_d & ~dco_spi_done;
    assign w_test_rise = ~r_test_d & dco_test_mode;

    ad_pattern_chk #(
        .N_CH     (N_CH),
        .DATA_W   (DATA_W),
        .TEST_PAT (TEST_PAT)
    ) u_pattern_chk (
        .clk_dco_div (clk_dco_div),
        .reset       (reset),
        .preset      (w_preset),
        .enable      (r_state == ST_TEST_CHK),
        .ch_data     (ch_data),
        .flags       (w_flags)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_fail_nxt      = r_fail;
        w_cnt_nxt       = r_cnt;
        w_match_nxt     = r_match;
        w_slip_nxt      = r_slip;
        w_bitslip_nxt   = 1'b0;
        w_aligned_nxt   = r_aligned;
        w_align_err_nxt = r_align_err;
        w_lock_lost_nxt = 1'b0;
        w_preset        = 1'b0;
        w_ch_ok_ld      = 1'b0;
        w_ch_ok_clr     = 1'b0;
        if (dco_soft_rst) begin
            w_state_nxt     = ST_RST_SERDES;
            w_fail_nxt      = 1'b0;
            w_cnt_nxt       = '0;
            w_match_nxt     = '0;
            w_slip_nxt      = '0;
            w_aligned_nxt   = 1'b0;
            w_align_err_nxt = 1'b0;
            w_ch_ok_clr     = 1'b1;
        end else if (w_spi_fall && (r_state != ST_RST_SERDES) && !r_fail) begin
            w_state_nxt   = ST_WAIT_SPI;
            w_cnt_nxt     = '0;
            w_match_nxt   = '0;
            w_slip_nxt    = '0;
            w_aligned_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_RST_SERDES: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_cnt_w'(RST_CYC - 1)) begin
                        w_state_nxt = ST_WAIT_SPI;
                        w_cnt_nxt   = '0;
                    end
                end
                // FAIL parks here with r_fail set; only a reset leaves it.
                ST_WAIT_SPI: begin
                    if (!r_fail && dco_spi_done) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SETTLE: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_cnt_w'(SETTLE_CYC - 1)) begin
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = '0;
                        w_match_nxt = '0;
                    end
                end
                ST_CHECK: begin
                    if (!r_frame_match) begin
                        w_state_nxt = ST_SLIP;
                    end else if (r_match == c_cnt_w'(MATCH_CNT - 1)) begin
                        if (dco_test_mode) begin
                            w_state_nxt = ST_TEST_CHK;
                            w_cnt_nxt   = '0;
                            w_preset    = 1'b1;
                        end else begin
                            w_state_nxt   = ST_LOCKED;
                            w_aligned_nxt = 1'b1;
                        end
                    end else begin
                        w_match_nxt = r_match + 1'b1;
                    end
                end
                ST_SLIP: begin
                    if (r_slip == 4'(DATA_W)) begin
                        w_state_nxt     = ST_WAIT_SPI;
                        w_fail_nxt      = 1'b1;
                        w_align_err_nxt = 1'b1;
                        w_aligned_nxt   = 1'b0;
                    end else begin
                        w_state_nxt   = ST_SLIP_WAIT;
                        w_bitslip_nxt = 1'b1;
                        w_slip_nxt    = r_slip + 4'd1;
                        w_cnt_nxt     = '0;
                    end
                end
                // Long enough for the slipped word to reach the registered compare.
                ST_SLIP_WAIT: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_cnt_w'(SLIP_WAIT - 1)) begin
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = '0;
                        w_match_nxt = '0;
                    end
                end
                ST_TEST_CHK: begin
                    if (!r_frame_match) begin
                        w_state_nxt   = ST_SLIP;
                        w_aligned_nxt = 1'b0;
                    end else if (r_cnt == c_cnt_w'(MATCH_CNT - 1)) begin
                        w_state_nxt   = ST_LOCKED;
                        w_aligned_nxt = 1'b1;
                        w_ch_ok_ld    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!r_frame_match) begin
                        w_state_nxt     = ST_SETTLE;
                        w_cnt_nxt       = '0;
                        w_slip_nxt      = '0;
                        w_aligned_nxt   = 1'b0;
                        w_lock_lost_nxt = 1'b1;
                    end else if (w_test_rise) begin
                        w_state_nxt = ST_TEST_CHK;
                        w_cnt_nxt   = '0;
                        w_preset    = 1'b1;
                    end
                end
                default: w_state_nxt = ST_RST_SERDES;
            endcase
        end
    end

    always_ff @(posedge clk_dco_div or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RST_SERDES;
            r_fail        <= 1'b0;
            r_cnt         <= '0;
            r_match       <= '0;
            r_slip        <= '0;
            r_bitslip     <= 1'b0;
            r_aligned     <= 1'b0;
            r_align_err   <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_serdes_rst  <= 1'b1;
            r_ch_ok       <= '0;
            r_frame_match <= 1'b0;
            r_spi_d       <= 1'b0;
            r_test_d      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fail        <= w_fail_nxt;
            r_cnt         <= w_cnt_nxt;
            r_match       <= w_match_nxt;
            r_slip        <= w_slip_nxt;
            r_bitslip     <= w_bitslip_nxt;
            r_aligned     <= w_aligned_nxt;
            r_align_err   <= w_align_err_nxt;
            r_lock_lost   <= w_lock_lost_nxt;
            r_serdes_rst  <= (w_state_nxt == ST_RST_SERDES);
            r_frame_match <= (frame_word == FRAME_PAT);
            r_spi_d       <= dco_spi_done;
            r_test_d      <= dco_test_mode;
            if (w_ch_ok_clr) begin
                r_ch_ok <= '0;
            end else if (w_ch_ok_ld) begin
                r_ch_ok <= w_flags;
            end
        end
    end

    assign serdes_rst = r_serdes_rst;
    assign bitslip    = r_bitslip;
    assign aligned    = r_aligned;
    assign align_err  = r_align_err;
    assign lock_lost  = r_lock_lost;
    assign ch_ok      = r_ch_ok;
    assign slip_cnt   = r_slip;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: doc/ad_align_ctrl.md
Name: ad_align_ctrl

Overview:
Bring-up and word-alignment controller for the AD9252 8-channel serial LVDS receive path, running in the divided DCO domain.
- Consumes the already-synchronised reset, soft-reset, SPI-done and test-mode levels.
- Resets the deserialisers and issues bitslip pulses until the deserialised FCO word matches the frame pattern.
- Optionally checks every channel against the ADC test pattern, then declares the link aligned to downstream capture logic.

Parameters:
N_CH, 8, number of ADC data channels.
DATA_W, 14, deserialised word width per channel and frame word width.
FRAME_PAT, 14'h3F80, expected deserialised FCO word.
TEST_PAT, 14'h2AAA, expected channel word while dco_test_mode=1.
RST_CYC, 8, cycles serdes_rst is held.
SETTLE_CYC, 16, cycles waited after spi_done before the first check.
SLIP_WAIT, 4, cycles after each bitslip before re-checking.
MATCH_CNT, 8, consecutive matching cycles required for a pass.

Ports:
clk_dco_div  in  1  divided DCO clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
dco_soft_rst  in  1  synchronised soft reset, level, synchronous restart.
dco_spi_done  in  1  synchronised ADC SPI configuration done, level.
dco_test_mode  in  1  synchronised ADC test-pattern mode, level.
frame_word  in  DATA_W  deserialised FCO word, valid every cycle.
ch_data  in  N_CH*DATA_W  deserialised channel words; channel i occupies [i*DATA_W +: DATA_W].
serdes_rst  out  1  deserialiser reset.
bitslip  out  1  single-cycle bitslip pulse to all deserialisers.
aligned  out  1  frame lock achieved; downstream capture enable.
align_err  out  1  alignment failed, sticky.
lock_lost  out  1  one-cycle pulse when lock drops in LOCKED.
ch_ok  out  N_CH  per-channel test-pattern pass result.
slip_cnt  out  4  bitslips issued in the current attempt.
state_dbg  out  3  current state encoding.

Behaviour:
- Reset value of every output:
  - serdes_rst=1.
  - bitslip=0, aligned=0, align_err=0, lock_lost=0.
  - ch_ok=0, slip_cnt=0.
  - state RST_SERDES.
- Priority: reset > dco_soft_rst > all other transitions.
- dco_soft_rst=1 in any state: next state RST_SERDES; all counters and outputs return to reset values on the next edge.
- RST_SERDES: serdes_rst=1 for RST_CYC cycles, then go to WAIT_SPI with serdes_rst=0.
- WAIT_SPI: hold until dco_spi_done=1, then go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then go to CHECK with the match counter cleared.
- CHECK, one comparison per cycle:
  - frame_word==FRAME_PAT increments the match counter.
  - On reaching MATCH_CNT, go to TEST_CHK if dco_test_mode=1, else LOCKED.
  - Any mismatch goes to SLIP.
- SLIP:
  - If slip_cnt==DATA_W, go to FAIL with no pulse.
  - Otherwise bitslip=1 for exactly one cycle, slip_cnt+1, then go to SLIP_WAIT.
- SLIP_WAIT: SLIP_WAIT cycles, then go to CHECK with the match counter cleared.
- TEST_CHK:
  - Lasts MATCH_CNT cycles; a per-channel flag is preset to 1 on entry.
  - Flag i clears on any cycle where channel i != TEST_PAT.
  - On exit, ch_ok<=flags, then go to LOCKED.
  - A frame mismatch during TEST_CHK goes to SLIP.
- LOCKED:
  - aligned=1.
  - frame_word!=FRAME_PAT causes a lock_lost pulse, aligned=0, slip_cnt cleared, then SETTLE.
  - A dco_test_mode rising edge goes to TEST_CHK with aligned held at 1.
- FAIL: align_err=1, aligned=0; only reset or dco_soft_rst exit.
- dco_spi_done falling in any state except RST_SERDES or FAIL:
  - Go to WAIT_SPI.
  - aligned=0, slip_cnt cleared.
  - Has priority over CHECK/SLIP/LOCKED transitions.
- aligned changes only on state entry/exit and is registered.
- bitslip is never asserted in consecutive cycles.
- ch_ok holds its last value outside TEST_CHK and is cleared by reset and soft reset.
- Compares are registered: frame_word is sampled one cycle before the decision. SLIP_WAIT absorbs this latency.

Decomposition:
- Shared package ad_align_pkg:
  - 3-bit state encoding: RST_SERDES=0, WAIT_SPI=1, SETTLE=2, CHECK=3, SLIP=4, SLIP_WAIT=5, TEST_CHK=6, LOCKED=7.
  - FAIL encoded as a flag combined with state WAIT_SPI on state_dbg; state_dbg=7 with align_err=1 is reserved.
  - Default FRAME_PAT and TEST_PAT constants.
- One sub-module: ad_pattern_chk. It holds the registered per-channel TEST_PAT compare and sticky-flag vector (preset/clear-enable inputs, N_CH outputs).

Test Plan:
1. Reset released, dco_spi_done=1 at cycle 20, frame_word=14'h3F80 always:
   - serdes_rst high 8 cycles.
   - No bitslip.
   - aligned=1 after 16 settle + 8 match cycles; slip_cnt=0.
2. Frame misaligned by 3:
   - The model rotates frame_word on each bitslip.
   - Exactly 3 single-cycle bitslip pulses, at least 5 cycles apart.
   - aligned=1, slip_cnt=3.
3. frame_word never matches:
   - 14 bitslips, then align_err=1, aligned=0, no further pulses.
   - dco_soft_rst pulse restarts at RST_SERDES with align_err=0.
4. dco_test_mode=1, channels 0-6 = 14'h2AAA, channel 7 = 14'h2AAB for one cycle: ch_ok=8'h7F, aligned=1.
5. In LOCKED, corrupt frame_word for one cycle: lock_lost pulse, aligned=0, realignment via SETTLE, aligned=1 again.
6. dco_spi_done drops during SLIP_WAIT: state WAIT_SPI, slip_cnt=0, no bitslip until dco_spi_done returns and SETTLE completes.
